// File: rtl/bldc_pkg.sv
// Shared state type, fault codes and lookup helpers for the BLDC six-step commutation sequencer.
package bldc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        RUN,
        FAULT
    } state_t;

    localparam logic [1:0] FC_NONE   = 2'b00;
    localparam logic [1:0] FC_HALL   = 2'b01;
    localparam logic [1:0] FC_STALL  = 2'b10;
    localparam logic [2:0] STEP_NONE = 3'd7;

    // Hall code {C,B,A} to commutation step; 000 and 111 map to STEP_NONE.
    function automatic logic [2:0] hall_to_step(input logic [2:0] hall);
        case (hall)
            3'b001:  return 3'd0;
            3'b011:  return 3'd1;
            3'b010:  return 3'd2;
            3'b110:  return 3'd3;
            3'b100:  return 3'd4;
            3'b101:  return 3'd5;
            default: return STEP_NONE;
        endcase
    endfunction

    // Returns {hs, ls}; reverse rotation drives the same step with the sides swapped.
    function automatic logic [5:0] step_to_pattern(input logic [2:0] s, input logic rev);
        logic [2:0] h;
        logic [2:0] l;
        case (s)
            3'd0:    begin h = 3'b001; l = 3'b010; end
            3'd1:    begin h = 3'b001; l = 3'b100; end
            3'd2:    begin h = 3'b010; l = 3'b100; end
            3'd3:    begin h = 3'b010; l = 3'b001; end
            3'd4:    begin h = 3'b100; l = 3'b001; end
            3'd5:    begin h = 3'b100; l = 3'b010; end
            default: begin h = 3'b000; l = 3'b000; end
        endcase
        return rev ? {l, h} : {h, l};
    endfunction

endpackage

// File: rtl/bldc_commutation_sequencer_hall_filter.sv
// Hall input synchroniser plus stability filter: hall_f follows the synced value only after
// FILT_CYCLES consecutive identical samples; hall_f_chg pulses for one clock on each update.
module hall_filter #(
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall_in,
    output logic [2:0] hall_f,
    output logic       hall_f_chg
);

    logic [2:0] hall_m;
    logic [2:0] hall_s;
    logic [2:0] hall_p;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    // cnt is the length of the current run of identical samples, saturating at FILT_CYCLES.
    always_comb begin
        if (hall_s != hall_p)
            cnt_nxt = 8'd1;
        else if (cnt == 8'(FILT_CYCLES))
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hall_m     <= '0;
            hall_s     <= '0;
            hall_p     <= '0;
            cnt        <= '0;
            hall_f     <= '0;
            hall_f_chg <= 1'b0;
        end else begin
            hall_m     <= hall_in;
            hall_s     <= hall_m;
            hall_p     <= hall_s;
            cnt        <= cnt_nxt;
            hall_f_chg <= 1'b0;
            if (cnt_nxt == 8'(FILT_CYCLES) && hall_s != hall_f) begin
                hall_f     <= hall_s;
                hall_f_chg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bldc_commutation_sequencer.sv
// Six-step hall-driven BLDC commutation sequencer with dead time and PWM-gated high side.
// Optional stall detection is compiled in with `define STALL_DETECT_EN.
module bldc_commutation_sequencer
    import bldc_pkg::*;
#(
    parameter int unsigned FILT_CYCLES  = 4,
    parameter int unsigned DEAD_CYCLES  = 8,
    parameter int unsigned STALL_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       pwm_in,
    input  logic [2:0] hall_in,
    input  logic       fault_clr,
    output logic [2:0] hs,
    output logic [2:0] ls,
    output logic [2:0] step,
    output logic       comm_pulse,
    output logic       fault,
    output logic [1:0] fault_code
);

    logic [2:0] hall_f;
    logic       hall_f_chg;

    hall_filter #(
        .FILT_CYCLES(FILT_CYCLES)
    ) u_hall_filter (
        .clk       (clk),
        .rst       (rst),
        .hall_in   (hall_in),
        .hall_f    (hall_f),
        .hall_f_chg(hall_f_chg)
    );

    state_t     state;
    logic [2:0] tgt;
    logic       dir_l;
    logic [7:0] dead_cnt;
    logic [2:0] hall_step;
    logic       hall_ok;
    logic       new_tgt;
    logic [5:0] tgt_pat;
    logic       stall_hit;

    assign hall_step = hall_to_step(hall_f);
    assign hall_ok   = (hall_step != STEP_NONE);
    // Every hall_f update pulses hall_f_chg, so gating on it is equivalent to a level compare.
    assign new_tgt   = (hall_f_chg && hall_step != tgt) || (dir != dir_l);
    assign tgt_pat   = step_to_pattern(tgt, dir_l);

`ifdef STALL_DETECT_EN
    localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt;

    // Cleared whenever not in RUN; any re-entry to RUN passes through DEAD first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == RUN)
            stall_cnt <= stall_cnt + 1'b1;
        else
            stall_cnt <= '0;
    end

    assign stall_hit = (state == RUN) && (stall_cnt == STALL_W'(STALL_CYCLES - 1));
`else
    // Stall detection compiled out: STALL_CYCLES has no effect in this build.
    assign stall_hit = 1'b0 & (STALL_CYCLES != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tgt        <= '0;
            dir_l      <= 1'b0;
            dead_cnt   <= '0;
            hs         <= '0;
            ls         <= '0;
            step       <= STEP_NONE;
            comm_pulse <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            comm_pulse <= 1'b0;
            hs         <= '0;
            ls         <= '0;
            case (state)
                IDLE: begin
                    step <= STEP_NONE;
                    if (en && hall_ok) begin
                        state    <= DEAD;
                        tgt      <= hall_step;
                        step     <= hall_step;
                        dir_l    <= dir;
                        dead_cnt <= '0;
                    end
                end
                DEAD: begin
                    if (!hall_ok) begin
                        state      <= FAULT;
                        step       <= STEP_NONE;
                        fault      <= 1'b1;
                        fault_code <= FC_HALL;
                    end else if (!en) begin
                        state <= IDLE;
                        step  <= STEP_NONE;
                    end else if (new_tgt) begin
                        tgt      <= hall_step;
                        step     <= hall_step;
                        dir_l    <= dir;
                        dead_cnt <= '0;
                    end else if (dead_cnt == 8'(DEAD_CYCLES - 1)) begin
                        state <= RUN;
                        hs    <= tgt_pat[5:3] & {3{pwm_in}};
                        ls    <= tgt_pat[2:0];
                    end else begin
                        dead_cnt <= dead_cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (!hall_ok) begin
                        state      <= FAULT;
                        step       <= STEP_NONE;
                        fault      <= 1'b1;
                        fault_code <= FC_HALL;
                    end else if (stall_hit) begin
                        state      <= FAULT;
                        step       <= STEP_NONE;
                        fault      <= 1'b1;
                        fault_code <= FC_STALL;
                    end else if (!en) begin
                        state <= IDLE;
                        step  <= STEP_NONE;
                    end else if (new_tgt) begin
                        comm_pulse <= 1'b1;
                        state      <= DEAD;
                        tgt        <= hall_step;
                        step       <= hall_step;
                        dir_l      <= dir;
                        dead_cnt   <= '0;
                    end else begin
                        hs <= tgt_pat[5:3] & {3{pwm_in}};
                        ls <= tgt_pat[2:0];
                    end
                end
                FAULT: begin
                    if (fault_clr && !en) begin
                        state      <= IDLE;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bldc_commutation_sequencer.sv
// Self-checking bench: behavioural commutation model compared every cycle, plus literal checks.
module tb_bldc_commutation_sequencer;

    localparam int FILT  = 4;
    localparam int DEAD  = 8;
    localparam int STALL = 50;
`ifdef STALL_DETECT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       pwm_in = 1'b1;
    logic       fault_clr = 1'b0;
    logic [2:0] hall_in = 3'b000;
    logic [2:0] hs, ls, step;
    logic       comm_pulse, fault;
    logic [1:0] fault_code;

    int checks = 0;
    int failures = 0;

    bldc_commutation_sequencer #(
        .FILT_CYCLES (FILT),
        .DEAD_CYCLES (DEAD),
        .STALL_CYCLES(STALL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .pwm_in    (pwm_in),
        .hall_in   (hall_in),
        .fault_clr (fault_clr),
        .hs        (hs),
        .ls        (ls),
        .step      (step),
        .comm_pulse(comm_pulse),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Reference tables from the step map and forward drive table.
    int hall_step_of[8] = '{-1, 0, 2, 1, 4, 5, 3, -1};
    int pat_hs[6] = '{1, 1, 2, 2, 4, 4};
    int pat_ls[6] = '{2, 4, 4, 1, 1, 2};
    logic [2:0] hall_seq[6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    // Model: mode 0 idle, 1 dead, 2 run, 3 fault.
    logic [2:0] m_s1, m_s2, m_f;
    logic [2:0] m_hist[$];
    int         m_mode, m_tgt, m_dead_spent, m_run_spent;
    logic       m_dir;
    logic [2:0] m_hs, m_ls, m_step;
    logic       m_comm, m_fault;
    logic [1:0] m_code;

    task automatic enter_dead(input int ns);
        m_mode = 1;
        m_tgt = ns;
        m_dir = dir;
        m_dead_spent = 0;
    endtask

    task automatic go_fault(input logic [1:0] code);
        m_mode = 3;
        m_code = code;
    endtask

    task automatic model_fsm();
        int ns;
        bit change;
        int h, l;
        ns = hall_step_of[m_f];
        change = (ns != m_tgt) || (dir != m_dir);
        m_comm = 1'b0;
        case (m_mode)
            0: if (en && ns >= 0) enter_dead(ns);
            1: begin
                if (ns < 0) go_fault(2'b01);
                else if (!en) m_mode = 0;
                else if (change) enter_dead(ns);
                else begin
                    m_dead_spent = m_dead_spent + 1;
                    if (m_dead_spent == DEAD) begin
                        m_mode = 2;
                        m_run_spent = 0;
                    end
                end
            end
            2: begin
                if (ns < 0) go_fault(2'b01);
                else if (STALL_ON && m_run_spent + 1 == STALL) go_fault(2'b10);
                else if (!en) m_mode = 0;
                else if (change) begin
                    m_comm = 1'b1;
                    enter_dead(ns);
                end else m_run_spent = m_run_spent + 1;
            end
            default: if (fault_clr && !en) begin
                m_mode = 0;
                m_code = 2'b00;
            end
        endcase
        h = m_dir ? pat_ls[m_tgt] : pat_hs[m_tgt];
        l = m_dir ? pat_hs[m_tgt] : pat_ls[m_tgt];
        m_hs = (m_mode == 2) ? (3'(h) & {3{pwm_in}}) : 3'b000;
        m_ls = (m_mode == 2) ? 3'(l) : 3'b000;
        m_step = (m_mode == 1 || m_mode == 2) ? 3'(m_tgt) : 3'd7;
        m_fault = (m_mode == 3);
    endtask

    task automatic model_filter();
        bit same;
        m_hist.push_back(m_s2);
        if (m_hist.size() > FILT) void'(m_hist.pop_front());
        same = (m_hist.size() == FILT);
        for (int i = 1; i < m_hist.size(); i++)
            if (m_hist[i] != m_hist[0]) same = 1'b0;
        if (same) m_f = m_hist[0];
        m_s2 = m_s1;
        m_s1 = hall_in;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 3'b000; m_s2 = 3'b000; m_f = 3'b000;
            m_hist = {};
            m_mode = 0; m_tgt = 0; m_dir = 1'b0;
            m_dead_spent = 0; m_run_spent = 0;
            m_hs = 3'b000; m_ls = 3'b000; m_step = 3'd7;
            m_comm = 1'b0; m_fault = 1'b0; m_code = 2'b00;
        end else begin
            model_fsm();
            model_filter();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({hs, ls, step, comm_pulse, fault, fault_code} !==
                {m_hs, m_ls, m_step, m_comm, m_fault, m_code}) begin
                failures++;
                $display("FAIL model t=%0t got hs=%b ls=%b step=%0d comm=%b fault=%b code=%b want hs=%b ls=%b step=%0d comm=%b fault=%b code=%b",
                         $time, hs, ls, step, comm_pulse, fault, fault_code,
                         m_hs, m_ls, m_step, m_comm, m_fault, m_code);
            end
            checks++;
            if ((hs & ls) != 3'b000) begin
                failures++;
                $display("FAIL shoot_through t=%0t got hs=%b ls=%b want disjoint", $time, hs, ls);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        int seen, hold, pos, r, quiet;
        tick(3);
        rst = 1'b0;
        expect_eq("reset_outputs", {hs, ls, step, comm_pulse}, {3'b000, 3'b000, 3'd7, 1'b0});
        expect_eq("reset_fault", {fault, fault_code}, 3'b000);

        // Start-up: hall 001 forward, drive after 2+4+8+1 clocks.
        hall_in = 3'b001; en = 1'b1; dir = 1'b0; pwm_in = 1'b1;
        quiet = 0;
        for (int i = 1; i <= 14; i++) begin
            tick(1);
            quiet += ((hs | ls) != 3'b000) ? 1 : 0;
        end
        expect_eq("startup_quiet", quiet, 0);
        tick(1);
        expect_eq("startup_drive", {hs, ls, step}, {3'b001, 3'b010, 3'd0});

        // Commutation 001 -> 011.
        hall_in = 3'b011;
        tick(6);
        expect_eq("comm_before", {comm_pulse, hs, ls}, {1'b0, 3'b001, 3'b010});
        tick(1);
        expect_eq("comm_pulse", {comm_pulse, hs, ls, step}, {1'b1, 3'b000, 3'b000, 3'd1});
        quiet = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            quiet += (comm_pulse || (hs | ls) != 3'b000) ? 1 : 0;
        end
        expect_eq("comm_dead", quiet, 0);
        tick(1);
        expect_eq("comm_drive", {hs, ls, step}, {3'b001, 3'b100, 3'd1});

        // Three-clock glitch back to 001 must be rejected.
        hall_in = 3'b001;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            seen += comm_pulse;
            if (i == 2) hall_in = 3'b011;
        end
        expect_eq("glitch_no_comm", seen, 0);
        expect_eq("glitch_outputs", {hs, ls, step}, {3'b001, 3'b100, 3'd1});

        // Step 2 then reverse direction.
        hall_in = 3'b010;
        tick(16);
        expect_eq("step2_fwd", {hs, ls, step}, {3'b010, 3'b100, 3'd2});
        dir = 1'b1;
        tick(1);
        expect_eq("dir_comm", {comm_pulse, hs, ls}, {1'b1, 3'b000, 3'b000});
        tick(8);
        expect_eq("step2_rev", {hs, ls, step}, {3'b100, 3'b010, 3'd2});
        pwm_in = 1'b0;
        tick(1);
        expect_eq("pwm_low", {hs, ls}, {3'b000, 3'b010});
        pwm_in = 1'b1;
        tick(1);
        expect_eq("pwm_high", {hs, ls}, {3'b100, 3'b010});
        dir = 1'b0;
        tick(10);

        // Invalid hall in RUN latches a fault; clear works only with en low.
        hall_in = 3'b111;
        tick(8);
        expect_eq("hall_fault", {fault, fault_code, hs, ls, step}, {1'b1, 2'b01, 3'b000, 3'b000, 3'd7});
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        tick(1);
        expect_eq("clr_ignored", {fault, fault_code}, {1'b1, 2'b01});
        en = 1'b0; fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        expect_eq("clr_taken", {fault, fault_code, step}, {1'b0, 2'b00, 3'd7});
        hall_in = 3'b001; en = 1'b1;
        tick(16);
        expect_eq("restart", {hs, ls, step}, {3'b001, 3'b010, 3'd0});

        // Asynchronous reset mid-run.
        rst = 1'b1;
        #1;
        expect_eq("async_reset", {hs, ls, step, fault}, {3'b000, 3'b000, 3'd7, 1'b0});
        tick(2);
        rst = 1'b0;
        tick(15);
        expect_eq("after_reset", {hs, ls, step}, {3'b001, 3'b010, 3'd0});

        // Frozen hall in RUN.
`ifdef STALL_DETECT_EN
        tick(49);
        expect_eq("stall_before", fault, 1'b0);
        tick(1);
        expect_eq("stall_fault", {fault, fault_code, hs, ls}, {1'b1, 2'b10, 3'b000, 3'b000});
`else
        tick(1000);
        expect_eq("no_stall", {fault, fault_code, hs, step}, {1'b0, 2'b00, 3'b001, 3'd0});
`endif
        en = 1'b0; fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        tick(1);

        // Randomized run checked by the model.
        hold = 0; pos = 0;
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            fault_clr = ($urandom_range(0, 19) == 0);
            pwm_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) dir = ~dir;
            if (hold == 0) begin
                r = $urandom_range(0, 15);
                if (r == 0) begin
                    hall_in = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
                    hold = $urandom_range(2, 10);
                end else if (r < 3) begin
                    hall_in = hall_seq[$urandom_range(0, 5)];
                    hold = $urandom_range(1, 3);
                end else begin
                    pos = ($urandom_range(0, 3) == 0) ? (pos + 5) % 6 : (pos + 1) % 6;
                    hall_in = hall_seq[pos];
                    hold = $urandom_range(6, 40);
                end
            end else begin
                hold--;
            end
        end
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bldc_commutation_sequencer.md
Name: bldc_commutation_sequencer

Overview:
- Six-step trapezoidal commutation controller for the 3-phase BLDC bridge, driven by Hall sensors.
- Synchronises and filters the hall inputs, then maps each hall state to a step.
- Sequences the 6 gate-enable outputs, inserting dead time on every pattern change and gating the high side with an external PWM.
- Sits between the top-level pin mux and the gate-driver outputs; latches a fault on invalid hall codes.

Parameters:
FILT_CYCLES, 4, consecutive stable clocks required before a synced hall value is accepted (1..255)
DEAD_CYCLES, 8, all-off clocks inserted before any new drive pattern (1..255)
STALL_CYCLES, 1000000, clocks without commutation before stall fault (used only with STALL_DETECT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  run enable, level
dir  in  1  0 = forward, 1 = reverse
pwm_in  in  1  duty signal ANDed onto high-side outputs
hall_in  in  3  raw hall sensors {C,B,A}, asynchronous
fault_clr  in  1  single-cycle pulse that clears a latched fault
hs  out  3  high-side gate enables {C,B,A}
ls  out  3  low-side gate enables {C,B,A}
step  out  3  current commutation step 0..5; 7 = none
comm_pulse  out  1  one-cycle pulse on each accepted commutation
fault  out  1  latched fault flag
fault_code  out  2  00 none, 01 invalid hall, 10 stall

Behaviour:
- Interface decision: one clock, clk. Reset is rst, asynchronous and active-high.
- Reset values: hs=0, ls=0, step=7, comm_pulse=0, fault=0, fault_code=00. State is IDLE; synchronisers, filter and counters are cleared. Reset asserted mid-operation forces all outputs off immediately, without waiting for a clock edge.
- Hall synchroniser: 2-flop chain, producing hall_s.
- Hall filter:
  - hall_f loads hall_s once hall_s has been unchanged for FILT_CYCLES consecutive edges.
  - Any change of hall_s restarts the count.
  - hall_f resets to 000.
- Step map (hall_f -> step): 001->0, 011->1, 010->2, 110->3, 100->4, 101->5. Codes 000 and 111 are invalid.
- Forward drive pattern per step:
  - 0: A+ B-
  - 1: A+ C-
  - 2: B+ C-
  - 3: B+ A-
  - 4: C+ A-
  - 5: C+ B-
- Reverse drive (dir=1) uses the same step with the hs and ls vectors swapped.
- Output gating: hs = pattern_hs & {3{pwm_in}} (registered). ls = pattern_ls. hs[i] and ls[i] are never both 1.
- States:
  - IDLE: outputs off. Go to DEAD when en=1 and hall_f is valid.
  - DEAD: outputs off. Count DEAD_CYCLES, then go to RUN with the latched target step.
  - RUN: drive the pattern and update step.
  - FAULT: outputs off, fault=1.
- Commutation in RUN:
  - Trigger: hall_f changes to a valid, different step, or dir toggles.
  - Response: comm_pulse=1 for one cycle, the new target is latched, outputs go off on the next cycle, state goes to DEAD.
- Hall or dir change during DEAD: latch the new target and restart the dead counter.
- en=0 in DEAD or RUN: go to IDLE next cycle, outputs off, step=7. en has priority over a simultaneous hall change.
- Invalid hall_f in DEAD or RUN: go to FAULT, fault_code=01. Fault has priority over en and commutation.
- Leaving FAULT: only via fault_clr=1 while en=0, which goes to IDLE and clears fault and fault_code. fault_clr is ignored in other states.
- step output: reads 7 in IDLE and FAULT; holds the target step in DEAD and RUN.

Optional Feature:
- STALL_DETECT_EN defined:
  - A counter (width $clog2(STALL_CYCLES+1)) increments every clock in RUN.
  - It clears on comm_pulse and on leaving RUN.
  - Reaching STALL_CYCLES goes to FAULT with fault_code=10.
- Not defined: the counter is absent and fault_code 10 is never produced.

Decomposition:
- Package bldc_pkg:
  - state enum (IDLE, DEAD, RUN, FAULT)
  - fault code constants
  - hall-to-step lookup function
  - step-to-pattern function returning {hs,ls}
- Sub-module hall_filter: synchroniser plus stability counter, parameter FILT_CYCLES. Outputs hall_f and a one-cycle hall_f_chg.

Test Plan:
1. Reset, then hall_in=001, en=1, dir=0, pwm_in=1, FILT=4, DEAD=8 -> step=0 and hs=001, ls=010 after 2+4+8+1 clocks, with no earlier output activity.
2. In RUN, step hall 001->011 -> comm_pulse for 1 cycle, hs=ls=0 for exactly 8 cycles, then hs=001, ls=100, step=1.
3. Hall glitch 001->011->001 lasting 3 clocks -> no comm_pulse, outputs unchanged.
4. dir toggled 0->1 at step 2 -> 8 dead cycles, then hs=100, ls=010; pwm_in toggling is seen only on hs.
5. hall_in=111 held for 4+ cycles in RUN -> FAULT, all outputs 0, fault_code=01. fault_clr with en=1 is ignored. fault_clr with en=0 clears to IDLE.
6. STALL_DETECT_EN with STALL_CYCLES=50, hall frozen in RUN -> fault_code=10 after 50 RUN clocks. Without the macro, no fault occurs after 1000 clocks.
